// File: rtl/conv3x3_stream.sv
// conv3x3_stream
//   Streaming 3x3 convolution over an IMG_W x IMG_H frame. CH input channels
//   are summed into one signed output channel, a bias is added, and an
//   optional ReLU is applied. Coefficients (9 taps per channel, then a bias)
//   are loaded over a separate stream and kept across frames.
//
// Handshakes: every stream (w_*, s_*, m_*) transfers a beat in a cycle where
//   valid && ready are both high. A producer keeps valid and data stable
//   until the transfer. Ready may depend on the far side's ready (s_ready
//   follows m_ready), but no valid ever depends on a ready.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   start, load_w       frame start pulse (IDLE only); load coefficients first
//   w_valid/w_ready/w_data   coefficient stream, one tap per channel lane
//   s_valid/s_ready/s_data   pixel stream, raster order, one pixel per lane
//   m_valid/m_ready/m_data/m_last  result stream, m_last on the final result
//   busy, done          not-IDLE flag; one-cycle pulse after the last result
//   dbg_state           current FSM state (0 IDLE, 1 LOAD_W, 2 RUN, 3 DRAIN)
module conv3x3_stream #(
    parameter int DATA_W   = 9,
    parameter int WEIGHT_W = 16,
    parameter int CH       = 4,
    parameter int IMG_W    = 226,
    parameter int IMG_H    = 226,
    parameter int ACC_W    = 36,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       load_w,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [CH*WEIGHT_W-1:0]     w_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [CH*DATA_W-1:0]       s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [ACC_W-1:0]    m_data,
    output logic                       m_last,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 dbg_state
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = DATA_W + WEIGHT_W + 1;   // full-precision product width

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD_W = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3} state_t;

    state_t state_q, state_d;

    logic [3:0]                  wcnt_q;
    logic [CW-1:0]               c_q;
    logic [RW-1:0]               r_q;
    logic signed [WEIGHT_W-1:0]  taps_q [9][CH];
    logic signed [WEIGHT_W-1:0]  bias_q;
    logic [DATA_W-1:0]           lb0_q  [CH][IMG_W];   // row r-2
    logic [DATA_W-1:0]           lb1_q  [CH][IMG_W];   // row r-1
    logic [DATA_W-1:0]           win_q  [CH][3][2];    // window columns c-2, c-1
    logic                        m_valid_q, m_last_q, done_q;
    logic signed [ACC_W-1:0]     m_data_q;

    logic w_fire, s_fire, m_fire, last_px, win_ok;
    logic [DATA_W-1:0]           pix [CH];
    logic [DATA_W-1:0]           col [CH][3];          // incoming column: rows r-2, r-1, r
    logic [DATA_W-1:0]           p;
    logic signed [PW-1:0]        px_s, tap_s, prod;
    logic signed [ACC_W-1:0]     acc, result;

    assign w_fire  = w_valid && w_ready;
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid_q && m_ready;
    assign last_px = (r_q == RW'(IMG_H - 1)) && (c_q == CW'(IMG_W - 1));
    assign win_ok  = (r_q >= RW'(2)) && (c_q >= CW'(2));

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = load_w ? S_LOAD_W : S_RUN;
            S_LOAD_W: if (w_fire && wcnt_q == 4'd9) state_d = S_RUN;
            S_RUN:    if (s_fire && last_px) state_d = S_DRAIN;
            S_DRAIN:  if (m_fire && m_last_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_ready   = (state_q == S_LOAD_W);
        s_ready   = (state_q == S_RUN) && (!m_valid_q || m_ready);
        busy      = (state_q != S_IDLE);
        dbg_state = state_q;
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign done    = done_q;

    // Window columns: the two older rows come from the line buffers at the
    // current column, the newest row is the pixel being accepted.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            pix[k]    = s_data[k*DATA_W +: DATA_W];
            col[k][0] = lb0_q[k][c_q];
            col[k][1] = lb1_q[k][c_q];
            col[k][2] = pix[k];
        end
    end

    // Sum of all taps. Window column 2 is the incoming column, so the result
    // is ready in the accept cycle and registered into m_data.
    always_comb begin
        p     = '0;
        px_s  = '0;
        tap_s = '0;
        prod  = '0;
        acc   = {{(ACC_W-WEIGHT_W){bias_q[WEIGHT_W-1]}}, bias_q};
        for (int k = 0; k < CH; k++) begin
            for (int row = 0; row < 3; row++) begin
                for (int cc = 0; cc < 3; cc++) begin
                    p     = (cc == 2) ? col[k][row] : win_q[k][row][cc];
                    px_s  = {{(PW-DATA_W){1'b0}}, p};
                    tap_s = {{(PW-WEIGHT_W){taps_q[row*3+cc][k][WEIGHT_W-1]}}, taps_q[row*3+cc][k]};
                    prod  = px_s * tap_s;
                    acc   = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
                end
            end
        end
        result = acc;
        if (RELU_EN && (acc[ACC_W-1] || acc == '0)) result = '0;
    end

    // Line buffers and window: data only, never reset.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            for (int k = 0; k < CH; k++) begin
                lb0_q[k][c_q] <= lb1_q[k][c_q];
                lb1_q[k][c_q] <= pix[k];
                for (int row = 0; row < 3; row++) begin
                    win_q[k][row][0] <= win_q[k][row][1];
                    win_q[k][row][1] <= col[k][row];
                end
            end
        end
    end

    // Coefficients, counters and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q    <= '0;
            c_q       <= '0;
            r_q       <= '0;
            bias_q    <= '0;
            for (int t = 0; t < 9; t++)
                for (int k = 0; k < CH; k++)
                    taps_q[t][k] <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_DRAIN) && m_fire && m_last_q;

            if (w_fire) begin
                if (wcnt_q == 4'd9) begin
                    bias_q <= w_data[WEIGHT_W-1:0];
                    wcnt_q <= '0;
                end else begin
                    for (int k = 0; k < CH; k++)
                        taps_q[wcnt_q][k] <= w_data[k*WEIGHT_W +: WEIGHT_W];
                    wcnt_q <= wcnt_q + 4'd1;
                end
            end

            if (s_fire) begin
                if (c_q == CW'(IMG_W - 1)) begin
                    c_q <= '0;
                    r_q <= (r_q == RW'(IMG_H - 1)) ? '0 : r_q + RW'(1);
                end else begin
                    c_q <= c_q + CW'(1);
                end
            end

            if (s_fire && win_ok) begin
                m_valid_q <= 1'b1;
                m_data_q  <= result;
                m_last_q  <= last_px;
            end else if (m_fire) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
module tb_conv3x3_stream;

  localparam int ACC_W = 36;

  typedef struct {
    bit          sel;         // 0: 5x5 linear instance, 1: 4x4 ReLU instance
    bit          load;
    int          tap_idx;     // 0..8 single tap, 9 all taps
    logic [15:0] tap_val;
    bit          lane0_only;
    logic [15:0] bias;
    bit          ramp;        // pixel = r*W + c, else pix_val
    logic [8:0]  pix_val;
    int          stall_at;    // pixel index to stall before, -1 none
    longint      exp_base;
    bit          ramp_exp;    // expected steps by +1 per column, +5 per row
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, load_w, w_valid, s_valid, m_ready, sel;
  logic [63:0] w_data;
  logic [35:0] s_data;

  logic w_ready_a, s_ready_a, m_valid_a, m_last_a, busy_a, done_a;
  logic w_ready_b, s_ready_b, m_valid_b, m_last_b, busy_b, done_b;
  logic signed [ACC_W-1:0] m_data_a, m_data_b;
  logic [1:0] st_a, st_b;

  logic w_ready_m, s_ready_m, m_valid_m, m_last_m, busy_m, done_m;
  logic signed [ACC_W-1:0] m_data_m;
  logic [1:0] st_m;

  int checks = 0;
  int failures = 0;
  logic [ACC_W-1:0] exp_q[$];
  bit exp_last_q[$];
  bit mon_en = 1'b0;
  bit w_seen = 1'b0;
  vec_t vec[8];

  always #5 clk = ~clk;

  conv3x3_stream #(.IMG_W(5), .IMG_H(5), .RELU_EN(1'b0)) u_dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .load_w(load_w),
    .w_valid(w_valid), .w_ready(w_ready_a), .w_data(w_data),
    .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a),
    .busy(busy_a), .done(done_a), .dbg_state(st_a));

  conv3x3_stream #(.IMG_W(4), .IMG_H(4), .RELU_EN(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .load_w(load_w),
    .w_valid(w_valid), .w_ready(w_ready_b), .w_data(w_data),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b),
    .busy(busy_b), .done(done_b), .dbg_state(st_b));

  assign w_ready_m = sel ? w_ready_b : w_ready_a;
  assign s_ready_m = sel ? s_ready_b : s_ready_a;
  assign m_valid_m = sel ? m_valid_b : m_valid_a;
  assign m_last_m  = sel ? m_last_b  : m_last_a;
  assign m_data_m  = sel ? m_data_b  : m_data_a;
  assign busy_m    = sel ? busy_b    : busy_a;
  assign done_m    = sel ? done_b    : done_a;
  assign st_m      = sel ? st_b      : st_a;

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard: every result handshake is matched against the expected queue.
  always @(negedge clk) begin
    if (w_ready_m) w_seen = 1'b1;
    if (mon_en && !reset && m_valid_m && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %0d expected none", m_data_m);
      end else begin
        logic [ACC_W-1:0] e;
        bit l;
        e = exp_q.pop_front();
        l = exp_last_q.pop_front();
        check_val("m_data", $signed(m_data_m), $signed(e));
        check_val("m_last", longint'(m_last_m), longint'(l));
      end
    end
  end

  task automatic send_px(input logic [35:0] d);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (s_ready_m) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) timeout_fail("s_ready");
  endtask

  task automatic load_beat(input logic [63:0] d);
    bit ok = 1'b0;
    w_valid = 1'b1;
    w_data  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (w_ready_m) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    w_valid = 1'b0;
    if (!ok) timeout_fail("w_ready");
  endtask

  function automatic logic [35:0] pix_word(input vec_t v, input int k);
    logic [35:0] d;
    logic [8:0] pv;
    pv = v.ramp ? 9'(k) : v.pix_val;
    for (int l = 0; l < 4; l++) d[l*9 +: 9] = pv;
    return d;
  endfunction

  task automatic run_frame(input int idx);
    vec_t v;
    int n, w;
    bit got;
    logic [63:0] wd;
    longint e;
    v = vec[idx];
    w = v.sel ? 4 : 5;
    n = (w - 2) * (w - 2);
    for (int i = 0; i < n; i++) begin
      e = v.ramp_exp ? v.exp_base + (i / 3) * 5 + (i % 3) : v.exp_base;
      exp_q.push_back(e[ACC_W-1:0]);
      exp_last_q.push_back(i == n - 1);
    end
    sel = v.sel;
    w_seen = 1'b0;
    mon_en = 1'b1;

    start = 1'b1;
    load_w = v.load;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val($sformatf("busy_after_start[%0d]", idx), longint'(busy_m), 1);

    if (v.load) begin
      for (int b = 0; b < 9; b++) begin
        wd = '0;
        for (int l = 0; l < 4; l++)
          if ((v.tap_idx == 9 || v.tap_idx == b) && (!v.lane0_only || l == 0))
            wd[l*16 +: 16] = v.tap_val;
        load_beat(wd);
      end
      load_beat({48'h7fff_7fff_7fff, v.bias});
    end

    for (int k = 0; k < w * w; k++) begin
      if (k == v.stall_at) begin
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = pix_word(v, k);
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check_val("stall_s_ready", longint'(s_ready_m), 0);
          check_val("stall_m_valid", longint'(m_valid_m), 1);
          check_val("stall_m_data", $signed(m_data_m), $signed(exp_q[0]));
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
      send_px(pix_word(v, k));
    end

    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (done_m) got = 1'b1;
    end
    if (!got) timeout_fail($sformatf("done[%0d]", idx));
    else begin
      check_val($sformatf("busy_at_done[%0d]", idx), longint'(busy_m), 0);
      check_val($sformatf("state_idle[%0d]", idx), longint'(st_m), 0);
    end
    check_val($sformatf("results_left[%0d]", idx), longint'(exp_q.size()), 0);
    if (!v.load) check_val($sformatf("no_w_ready[%0d]", idx), longint'(w_seen), 0);
    exp_q.delete();
    exp_last_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_w_ready"}, longint'(w_ready_m), 0);
    check_val({tag, "_s_ready"}, longint'(s_ready_m), 0);
    check_val({tag, "_m_valid"}, longint'(m_valid_m), 0);
    check_val({tag, "_m_data"},  $signed(m_data_m), 0);
    check_val({tag, "_m_last"},  longint'(m_last_m), 0);
    check_val({tag, "_busy"},    longint'(busy_m), 0);
    check_val({tag, "_done"},    longint'(done_m), 0);
  endtask

  initial begin
    //            sel   load  tap val     lane0 bias      ramp  pix   stall exp         rampexp
    vec[0] = '{1'b1, 1'b1, 9, 16'd1,    1'b0, 16'd0,    1'b0, 9'd1,   -1, 36,         1'b0};
    vec[1] = '{1'b1, 1'b1, 9, 16'd1,    1'b0, 16'hFF9C, 1'b0, 9'd1,   -1, 0,          1'b0};
    vec[2] = '{1'b0, 1'b1, 9, 16'd1,    1'b0, 16'hFF9C, 1'b0, 9'd1,   -1, -64,        1'b0};
    vec[3] = '{1'b0, 1'b1, 0, 16'd1,    1'b1, 16'd0,    1'b1, 9'd0,   -1, 0,          1'b1};
    vec[4] = '{1'b0, 1'b1, 8, 16'd1,    1'b1, 16'd0,    1'b1, 9'd0,   -1, 12,         1'b1};
    vec[5] = '{1'b0, 1'b0, 8, 16'd1,    1'b1, 16'd0,    1'b1, 9'd0,   14, 12,         1'b1};
    vec[6] = '{1'b0, 1'b1, 9, 16'h8000, 1'b0, 16'd0,    1'b0, 9'd511, -1, -602800128, 1'b0};
    vec[7] = '{1'b0, 1'b0, 8, 16'd1,    1'b1, 16'd0,    1'b1, 9'd0,   -1, 0,          1'b0};

    reset = 1'b1;
    start = 1'b0;
    load_w = 1'b0;
    w_valid = 1'b0;
    w_data = '0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst_a");
    sel = 1'b1;
    #1;
    check_idle_outputs("rst_b");
    sel = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_state_a", longint'(st_a), 0);
    check_val("rst_state_b", longint'(st_b), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_frame(i);

    // Abort mid-RUN: nothing from the partial frame may appear, and the
    // reset coefficients leave only the zero bias.
    sel = 1'b0;
    mon_en = 1'b0;
    start = 1'b1;
    load_w = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 15; k++) send_px({4{9'd3}});
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    check_val("abort_state", longint'(st_a), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_frame(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
